// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - framed serial-to-parallel receiver with one-word holding register
module shift_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             sync,
    input  logic             dir,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clear_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic             dir_q, dir_n;
    logic             word_done;
    logic             abort;
    logic             drain;

    // Next-state view of the assembler; a sync bit restarts from an empty register
    // using the freshly latched bit order, so any partial word is simply overwritten.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sr_n      = sr;
        dir_n     = dir_q;
        word_done = 1'b0;
        abort     = 1'b0;
        if (bit_valid) begin
            if (sync) begin
                abort   = (state == SHIFT) && (cnt != '0);
                state_n = SHIFT;
                dir_n   = dir;
                cnt_n   = CW'(1);
                sr_n    = dir ? {bit_in, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, bit_in};
            end else if (state == SHIFT) begin
                sr_n = dir_q ? {bit_in, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], bit_in};
                if (cnt == CW'(WIDTH - 1)) begin
                    word_done = 1'b1;
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        end
    end

    assign drain = out_valid && out_ready;

    // Register assembler state, holding register and all status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            cnt       <= '0;
            sr        <= '0;
            dir_q     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sr        <= sr_n;
            dir_q     <= dir_n;
            busy      <= (state_n == SHIFT) && (cnt_n != '0);
            frame_err <= abort;
            if (word_done) begin
                if (!out_valid || out_ready) begin
                    out_data  <= sr_n;
                    out_valid <= 1'b1;
                end
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            // A new drop wins over a simultaneous clear so no overrun is ever lost.
            if (word_done && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel receiver for the team's shift-register datapath. It captures a framed serial bit stream, either MSB-first or LSB-first, and presents each completed WIDTH-bit word on a valid/ready output with a one-word holding register. It is the receiving end for words that a shift register serializes with a parallel load followed by left or right shifts.

## Interface
- WIDTH, 4, word length in bits; legal range 2 to 32.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; 0 resets the block immediately.
- bit_in  input  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies bit_in for one cycle.
- sync  input  1  frame marker; with bit_valid=1, marks bit_in as bit 0 of a new word.
- dir  input  1  bit order. 0 = MSB-first: bits enter at bit 0 and shift toward the MSB. 1 = LSB-first: bits enter at bit WIDTH-1 and shift toward bit 0.
- out_data  output  WIDTH  completed word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid=1 and out_ready=1.
- busy  output  1  a partial word is being assembled.
- frame_err  output  1  one-cycle pulse when sync aborts a partial word.
- overrun  output  1  sticky; a completed word was dropped because the holding register was full.
- clear_err  input  1  synchronous clear of overrun.

## Operation
- States:
  - HUNT: not aligned; waits for sync.
  - SHIFT: aligned; collects bits.
- HUNT transitions:
  - bit_valid=1 and sync=0: bit ignored.
  - bit_valid=1 and sync=1: bit stored as bit 0, bit count becomes 1, dir is latched, go to SHIFT.
- SHIFT, on each bit_valid=1:
  - dir=0: shift register becomes {sr[WIDTH-2:0], bit_in}.
  - dir=1: shift register becomes {bit_in, sr[WIDTH-1:1]}.
  - Bit count increments.
- dir is latched only on the sync bit. Changes to dir mid-frame have no effect until the next sync.
- Word completion: when the WIDTH-th bit is sampled, the word (including that bit) is transferred to the holding register. Bit count returns to 0 and the state stays SHIFT. Framing is continuous, so the next valid bit is bit 0 of the next word with no new sync needed.
- sync=1 with bit_valid=1 while in SHIFT:
  - Count is 0: normal realignment, no error.
  - Count is nonzero: the partial word is discarded, frame_err pulses, and bit_in becomes bit 0 of a new word.
- Holding register, when a word completes:
  - Empty, or drained in the same cycle (out_valid=1 and out_ready=1): load the word; out_valid=1.
  - Full and not drained: drop the word and set overrun. out_data and out_valid are unchanged.
- Drain with no completion in the same cycle: out_valid goes to 0; out_data holds its last value.
- overrun stays set until clear_err=1. If clear_err and a new overrun occur in the same cycle, overrun stays set.
- busy = (state==SHIFT) and (bit count != 0).
- bit_valid=0 cycles are bubbles: no state change, any length.

## Timing
- Reset values:
  - State HUNT, bit count 0, shift register 0, dir latch 0.
  - out_data=0, out_valid=0, busy=0, frame_err=0, overrun=0.
- All outputs are registered. No combinational path from inputs to outputs.
- Latency: if the last bit of a word is sampled at edge k, out_valid=1 and out_data are valid after edge k.
- Throughput: one word per WIDTH valid bits. Back-to-back words with bit_valid held high are sustained when out_ready=1.
- frame_err is high for exactly the cycle after the aborting sync edge.
- Reset asserted mid-word: the partial word and the held word are lost, and the block returns to HUNT. Bits after reset release are ignored until sync.

## Test plan
1. WIDTH=4, dir=0, out_ready=1: sync with first bit; bits 1,0,1,1 on consecutive cycles -> out_data=4'b1011, out_valid=1 for one cycle after the 4th edge; busy=1 after bits 1-3.
2. dir=1, same bits 1,0,1,1 -> out_data=4'b1101. Toggling dir mid-frame -> same result.
3. out_ready=0; words 1010 then 0110 -> out_data stays 4'b1010, overrun=1. Raise out_ready -> out_valid drops; overrun stays 1 until clear_err pulse.
4. Word 1010 held, out_ready=1 on the cycle word 0110 completes -> out_valid stays 1, out_data=4'b0110, overrun=0.
5. After bits 1,1 (count=2), sync with bit 0 then bits 0,1,1 -> frame_err pulses once; next word=4'b0011.
6. reset low after 2 bits; release; bits 1,1,1,1 without sync -> out_valid stays 0, busy=0. Then sync with 0,0,0,1 -> out_data=4'b0001.
